deflate_bit_packer: RTL and testbench

- Parametrised successor to the stream writer. Packs variable-length DEFLATE fields (Huffman codes, extra bits, header fields) LSB-first into fixed-width output words, with valid/ready handshakes on both sides.
- Optional per-symbol bit reversal handles Huffman codes, which are sent MSB-first. Flush pads to a byte boundary, tags the last word and reports its byte count.
- Sits between the Huffman encoder/symbol mux and the output RAM/file dumper.

---
 rtl/deflate_bit_packer.sv | 146 ++++++++++++++
 tb/tb_deflate_bit_packer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deflate_bit_packer.sv
// LSB-first bit packer for DEFLATE fields: variable-length symbols go in, fixed-width words come out.
// A flush pads the stream to a byte boundary and tags the final word with out_last and its byte count.
module deflate_bit_packer #(
  parameter int MAX_LEN = 16,
  parameter int OUT_W   = 32,
  parameter int CNT_W   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [MAX_LEN-1:0]             in_bits,
  input  logic [$clog2(MAX_LEN+1)-1:0]   in_len,
  input  logic                           in_rev,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic [$clog2(OUT_W/8+1)-1:0]   out_bytes,
  output logic                           out_last,
  output logic [CNT_W-1:0]               total_bits,
  output logic                           len_err,
  output logic                           busy
);

  localparam int LEN_W   = $clog2(MAX_LEN+1);
  localparam int ACC_W   = OUT_W + MAX_LEN;
  localparam int FILL_W  = $clog2(ACC_W+1);
  localparam int BYTES_W = $clog2(OUT_W/8+1);
  localparam logic [FILL_W-1:0]  OUT_W_F   = FILL_W'(OUT_W);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(OUT_W/8);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic [FILL_W-1:0]    fill, fill_nxt;
  logic [OUT_W-1:0]     word_nxt;
  logic [BYTES_W-1:0]   bytes_nxt;
  logic                 last_nxt;

  logic [LEN_W-1:0]     len_eff;
  logic [LEN_W-1:0]     len_shift;
  logic [MAX_LEN-1:0]   bits_rev;
  logic [MAX_LEN-1:0]   len_mask;
  logic [MAX_LEN-1:0]   field;
  logic                 accept;
  logic                 word_full;
  logic                 out_free;
  logic                 load_word;
  logic                 load_final;

  assign len_eff   = (in_len > MAX_LEN_L) ? MAX_LEN_L : in_len;
  assign len_shift = MAX_LEN_L - len_eff;

  always_comb begin
    bits_rev = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      bits_rev[i] = in_bits[MAX_LEN-1-i];
    end
  end

  // Reversing the whole port then shifting down leaves the low len_eff bits reversed at bit 0.
  assign len_mask = {MAX_LEN{1'b1}} >> len_shift;
  assign field    = (in_rev ? (bits_rev >> len_shift) : in_bits) & len_mask;

  assign word_full  = (fill >= OUT_W_F);
  assign out_free   = !out_valid || out_ready;
  assign in_ready   = !reset && (state == ST_RUN) && !word_full;
  assign accept     = in_valid && in_ready;
  assign load_word  = word_full && out_free;
  assign load_final = (state == ST_FLUSH) && !word_full && out_free;
  assign busy       = (state == ST_FLUSH);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush) state_nxt = ST_FLUSH;
      ST_FLUSH: if (load_final) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    acc_nxt   = acc;
    fill_nxt  = fill;
    word_nxt  = out_data;
    bytes_nxt = out_bytes;
    last_nxt  = out_last;
    if (accept) begin
      acc_nxt  = acc | (ACC_W'(field) << fill);
      fill_nxt = fill + FILL_W'(len_eff);
    end else if (load_word) begin
      word_nxt  = acc[OUT_W-1:0];
      bytes_nxt = FULL_BYTES;
      last_nxt  = 1'b0;
      acc_nxt   = acc >> OUT_W;
      fill_nxt  = fill - OUT_W_F;
    end else if (load_final) begin
      // Bits above fill are already zero; the mask keeps the padding explicit.
      word_nxt  = acc[OUT_W-1:0] & ~({OUT_W{1'b1}} << fill);
      bytes_nxt = BYTES_W'((fill + FILL_W'(7)) >> 3);
      last_nxt  = 1'b1;
      acc_nxt   = '0;
      fill_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      fill       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_bytes  <= '0;
      out_last   <= 1'b0;
      total_bits <= '0;
      len_err    <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      fill      <= fill_nxt;
      out_data  <= word_nxt;
      out_bytes <= bytes_nxt;
      out_last  <= last_nxt;
      if (load_word || load_final) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        total_bits <= total_bits + CNT_W'(len_eff);
        if (in_len > MAX_LEN_L) len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_deflate_bit_packer.sv
// Scoreboard bench for deflate_bit_packer: a bit-queue reference model predicts every output word,
// and a separate monitor pops and compares whenever a word is handed over.
module tb_deflate_bit_packer;

  localparam int MAX_LEN = 16;
  localparam int OUT_W   = 32;
  localparam int CNT_W   = 32;
  localparam int LEN_W   = $clog2(MAX_LEN+1);
  localparam int BYTES_W = $clog2(OUT_W/8+1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_rev = 1'b0;
  logic                 flush = 1'b0;
  logic                 out_ready = 1'b0;
  logic [MAX_LEN-1:0]   in_bits = '0;
  logic [LEN_W-1:0]     in_len = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [BYTES_W-1:0]   out_bytes;
  logic                 out_last;
  logic [CNT_W-1:0]     total_bits;
  logic                 len_err;
  logic                 busy;

  always #5 clk = ~clk;

  deflate_bit_packer #(.MAX_LEN(MAX_LEN), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_len(in_len), .in_rev(in_rev),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
    .out_last(out_last), .total_bits(total_bits), .len_err(len_err), .busy(busy)
  );

  typedef struct {
    logic [OUT_W-1:0]   data;
    logic [BYTES_W-1:0] bytes;
    logic               last;
  } word_t;

  word_t               expq[$];
  bit                  bitq[$];
  longint unsigned     exp_total = 0;
  int                  checks = 0;
  int                  failures = 0;
  bit                  mon_en = 1'b0;
  bit                  flush_busy = 1'b0;
  bit                  stall_prev = 1'b0;
  logic [OUT_W+BYTES_W:0] held;
  logic [OUT_W-1:0]    last_word = '0;
  int                  words_seen = 0;
  word_t               mw;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the stream is just a queue of bits in transmission order.
  task automatic model_push(logic [MAX_LEN-1:0] bits, int len, bit rev);
    int l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < l; i++) bitq.push_back(rev ? bits[l-1-i] : bits[i]);
    exp_total += l;
    while (bitq.size() >= OUT_W) begin
      word_t w;
      w.data = '0;
      for (int i = 0; i < OUT_W; i++) w.data[i] = bitq.pop_front();
      w.bytes = BYTES_W'(OUT_W/8);
      w.last  = 1'b0;
      expq.push_back(w);
    end
  endtask

  task automatic model_flush();
    word_t w;
    int n = bitq.size();
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i] = bitq.pop_front();
    w.bytes = BYTES_W'((n + 7) / 8);
    w.last  = 1'b1;
    expq.push_back(w);
    flush_busy = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) chk("hold_stable", {out_valid, out_last, out_bytes, out_data}, {1'b1, held});
      if (out_valid && out_ready) begin
        words_seen++;
        last_word = out_data;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          mw = expq.pop_front();
          chk("word_data", out_data, mw.data);
          chk("word_bytes", out_bytes, mw.bytes);
          chk("word_last", out_last, mw.last);
          if (mw.last) flush_busy = 1'b0;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_last, out_bytes, out_data};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(logic [MAX_LEN-1:0] bits, int len, bit rev);
    int t = 0;
    in_valid = 1'b1;
    in_bits  = bits;
    in_len   = LEN_W'(len);
    in_rev   = rev;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_push(bits, len, rev);
        break;
      end
      t++;
      if (t > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=no_accept required=accept");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    if (in_valid && in_ready) model_push(in_bits, int'(in_len), in_rev);
    model_flush();
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_after_flush", busy, 1);
    chk("in_ready_in_flush", in_ready, 0);
  endtask

  task automatic wait_idle(string name);
    int t = 0;
    while ((flush_busy || expq.size() != 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (flush_busy || expq.size() != 0) begin
      failures++;
      $display("FAIL %s actual=pending_%0d required=pending_0", name, expq.size());
    end
  endtask

  initial begin
    int acc_cnt;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_bytes", out_bytes, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_total", total_bits, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // Short header-style stream padded by flush
    send(16'b110, 3, 1'b0);
    send(16'b00011, 5, 1'b1);
    chk("tp1_total", total_bits, 8);
    do_flush();
    wait_idle("tp1_idle");
    chk("tp1_word", last_word, 32'h0000_00C6);
    chk("tp1_busy_clear", busy, 0);

    // Full words at full rate
    for (int i = 0; i < 4; i++) send(16'hABCD, 16, 1'b0);
    wait_idle("tp2_idle");
    chk("tp2_word", last_word, 32'hABCD_ABCD);
    chk("tp2_total", total_bits, 72);

    // Backpressure: accumulator fills behind a held output word
    out_ready = 1'b0;
    in_valid = 1'b1; in_bits = 16'hFFFF; in_len = LEN_W'(16); in_rev = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cnt++;
        model_push(16'hFFFF, 16, 1'b0);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc_cnt, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_out_data", out_data, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    wait_idle("bp_drain");
    chk("bp_resume", in_ready, 1);

    // Flush with nothing buffered
    do_flush();
    wait_idle("empty_flush_idle");
    chk("empty_flush_word", last_word, 0);

    // Over-long length is clamped and sticks in len_err
    send(16'hFFFF, 20, 1'b0);
    chk("len_err_set", len_err, 1);
    chk("len_err_total", total_bits, exp_total[CNT_W-1:0]);
    send(16'h0005, 3, 1'b1);
    chk("len_err_sticky", len_err, 1);
    do_flush();
    wait_idle("len_flush_idle");

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bits   = MAX_LEN'($urandom);
      in_len    = LEN_W'($urandom_range(0, MAX_LEN));
      in_rev    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = !flush_busy && ($urandom_range(0, 40) == 0);
      @(negedge clk);
      chk("total_bits", total_bits, exp_total[CNT_W-1:0]);
      if (in_valid && in_ready) model_push(in_bits, int'(in_len), in_rev);
      if (flush) model_flush();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_drain");
    do_flush();
    wait_idle("rand_final_flush");
    chk("rand_total", total_bits, exp_total[CNT_W-1:0]);
    chk("rand_len_err", len_err, 1);

    // Asynchronous reset while a flush is pending behind a stalled word
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16, 1'b0);
    do_flush();
    @(posedge clk); #1;
    chk("pre_rst_out_valid", out_valid, 1);
    mon_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_total", total_bits, 0);
    chk("async_busy", busy, 0);
    chk("async_len_err", len_err, 0);
    expq.delete();
    bitq.delete();
    exp_total = 0;
    flush_busy = 1'b0;
    stall_prev = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    send(16'h1234, 16, 1'b0);
    send(16'h5678, 16, 1'b0);
    wait_idle("post_rst_idle");
    chk("post_rst_word", last_word, 32'h5678_1234);
    chk("post_rst_total", total_bits, 32);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
